// File: rtl/aes_key_memory_if.sv
// rtl/aes_key_memory_if.sv - key-memory bus: init/key in, round-key read port, shared S-box link
interface aes_key_memory_if;
  logic         init;
  logic [127:0] key;
  logic [3:0]   round;
  logic [127:0] roundKey;
  logic [31:0]  sBoxRequest;
  logic [31:0]  sBoxResponse;
  logic         ready;

  // Key memory side
  modport slave (
    input  init, key, round, sBoxResponse,
    output roundKey, sBoxRequest, ready
  );

  // Encryption block / top-level side
  modport master (
    output init, key, round, sBoxResponse,
    input  roundKey, sBoxRequest, ready
  );
endinterface

// File: rtl/aes_key_memory.sv
// rtl/aes_key_memory.sv - AES-128 key expansion into 11 round-key slots with combinational read port
module aes_key_memory #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic               clk,
  input  logic               reset,
  aes_key_memory_if.slave    bus
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, INIT, GEN} state_t;

  state_t       state_q, state_d;
  logic         ready_q, ready_d;
  logic [3:0]   ctr_q, ctr_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] prev_q, prev_d;
  logic [127:0] slot_q [0:NUM_ROUNDS];

  logic         wr_en;
  logic [3:0]   wr_idx;
  logic [127:0] wr_data;

  logic [31:0]  w0, w1, w2, w3, t, k0, k1, k2, k3;
  logic [127:0] new_key;
  logic [7:0]   rcon_next;

  assign w0 = prev_q[127:96];
  assign w1 = prev_q[95:64];
  assign w2 = prev_q[63:32];
  assign w3 = prev_q[31:0];

  // S-box is fed the unrotated last word; rotation is applied on the response
  assign bus.sBoxRequest = (state_q == GEN) ? w3 : 32'h0;

  assign t  = {bus.sBoxResponse[23:0], bus.sBoxResponse[31:24]} ^ {rcon_q, 24'h0};
  assign k0 = w0 ^ t;
  assign k1 = w1 ^ k0;
  assign k2 = w2 ^ k1;
  assign k3 = w3 ^ k2;
  assign new_key = {k0, k1, k2, k3};

  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (8'h1b & {8{rcon_q[7]}});

  assign bus.ready    = ready_q;
  assign bus.roundKey = (bus.round <= LAST) ? slot_q[bus.round] : 128'h0;

  // Next-state and slot-write control for the expansion sequencer
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    ctr_d   = ctr_q;
    rcon_d  = rcon_q;
    prev_d  = prev_q;
    wr_en   = 1'b0;
    wr_idx  = ctr_q;
    wr_data = new_key;
    case (state_q)
      IDLE: begin
        if (bus.init) begin
          state_d = INIT;
          ready_d = 1'b0;
        end
      end
      INIT: begin
        wr_en   = 1'b1;
        wr_idx  = 4'd0;
        wr_data = bus.key;
        prev_d  = bus.key;
        ctr_d   = 4'd1;
        rcon_d  = 8'h01;
        state_d = GEN;
      end
      GEN: begin
        wr_en  = 1'b1;
        prev_d = new_key;
        ctr_d  = ctr_q + 4'd1;
        rcon_d = rcon_next;
        if (ctr_q == LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Sequencer state; reset aborts any expansion in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      ctr_q   <= 4'd0;
      rcon_q  <= 8'h01;
      prev_q  <= 128'h0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ctr_q   <= ctr_d;
      rcon_q  <= rcon_d;
      prev_q  <= prev_d;
    end
  end

  // Round-key slots, one written per cycle during INIT/GEN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= 128'h0;
    end else if (wr_en) begin
      slot_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_aes_key_memory.sv
// tb/tb_aes_key_memory.sv - directed FIPS-197 vectors for aes_key_memory
`timescale 1ns/100ps
module tb_aes_key_memory;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KEY_Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  aes_key_memory_if ifc ();

  aes_key_memory #(.NUM_ROUNDS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #50 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] x);
    int idx;
    idx = 2040 - 8 * int'(x);
    return SBOX[idx +: 8];
  endfunction

  assign ifc.sBoxResponse = {sb(ifc.sBoxRequest[31:24]), sb(ifc.sBoxRequest[23:16]),
                             sb(ifc.sBoxRequest[15:8]),  sb(ifc.sBoxRequest[7:0])};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_key(input int r, output logic [127:0] k);
    ifc.round = 4'(r);
    #1;
    k = ifc.roundKey;
  endtask

  // Counts edges from the init edge (inclusive) to the one that raises ready
  task automatic run_init(input logic [127:0] k, input bit hold, output int edges);
    ifc.key  = k;
    ifc.init = 1'b1;
    tick();
    if (!hold) ifc.init = 1'b0;
    edges = 1;
    while (!ifc.ready && edges < 40) begin
      tick();
      edges++;
    end
    ifc.init = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    logic [127:0] k;
    for (int r = 0; r <= 10; r++) begin
      read_key(r, k);
      check($sformatf("%s_round%0d", tag, r), k, 128'h0);
    end
  endtask

  initial begin
    logic [127:0] k;
    int edges;

    reset    = 1'b1;
    ifc.init = 1'b0;
    ifc.key  = 128'h0;
    ifc.round = 4'd0;
    #1;
    // T1: asynchronous reset state, before any clock edge
    check("t1_ready", 128'(ifc.ready), 128'd1);
    check("t1_sbox_req", 128'(ifc.sBoxRequest), 128'h0);
    check_all_zero("t1");
    @(negedge clk);
    reset = 1'b0;
    tick();

    // T2/T3: FIPS-197 A.1 expansion with cycle-level checks
    ifc.key  = KEY_A;
    ifc.init = 1'b1;
    tick();
    ifc.init = 1'b0;
    check("t2_ready_drop", 128'(ifc.ready), 128'd0);
    check("t3_sbox_init", 128'(ifc.sBoxRequest), 128'h0);
    tick();
    check("t3_sbox_gen1", 128'(ifc.sBoxRequest), 128'h09cf4f3c);
    edges = 2;
    while (!ifc.ready && edges < 40) begin
      tick();
      edges++;
    end
    check("t2_ready_edges", 128'(edges), 128'd12);
    check("t3_gen_cycles", 128'(edges - 2), 128'd10);
    check("t3_sbox_idle", 128'(ifc.sBoxRequest), 128'h0);
    read_key(0, k);  check("t2_round0", k, KEY_A);
    read_key(1, k);  check("t2_round1", k, KEY_A1);
    read_key(10, k); check("t2_round10", k, KEY_A10);

    // T6: out-of-range rounds read as zero
    for (int r = 11; r <= 15; r++) begin
      read_key(r, k);
      check($sformatf("t6_round%0d", r), k, 128'h0);
    end

    // T4: init held through the expansion does not restart it
    run_init(KEY_A, 1'b1, edges);
    check("t4_hold_edges", 128'(edges), 128'd12);
    read_key(10, k); check("t4_hold_round10", k, KEY_A10);
    tick();
    check("t4_idle_after_hold", 128'(ifc.ready), 128'd1);
    run_init(128'h0, 1'b0, edges);
    check("t4_zero_edges", 128'(edges), 128'd12);
    read_key(0, k);  check("t4_zero_round0", k, 128'h0);
    read_key(1, k);  check("t4_zero_round1", k, KEY_Z1);
    read_key(10, k); check("t4_zero_round10", k, KEY_Z10);

    // T5: reset five cycles into GEN aborts and clears everything
    ifc.key  = KEY_A;
    ifc.init = 1'b1;
    tick();
    ifc.init = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("t5_mid_gen_ready", 128'(ifc.ready), 128'd0);
    #2;
    reset = 1'b1;
    #1;
    check("t5_reset_ready", 128'(ifc.ready), 128'd1);
    check("t5_reset_sbox", 128'(ifc.sBoxRequest), 128'h0);
    check_all_zero("t5");
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_init(KEY_A, 1'b0, edges);
    check("t5_reinit_edges", 128'(edges), 128'd12);
    read_key(0, k);  check("t5_round0", k, KEY_A);
    read_key(1, k);  check("t5_round1", k, KEY_A1);
    read_key(10, k); check("t5_round10", k, KEY_A10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
